// File: rtl/rv_pkg.sv
// rv_pkg: constants and inter-stage bundles shared by the fetch stage.
// Holds XLEN, RESET_PC, the NOP encoding and the IF->ID queue entry type.
package rv_pkg;

  localparam int          XLEN        = 32;
  localparam int          DEPTH       = 2;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
  localparam logic [31:0] IALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush, occupancy count, full/empty.
// Ports: i_flush/i_push/i_wdata/i_pop in; o_rdata (head), o_count, o_full, o_empty out.
module fetch_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic          w_push;

  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_rdata = r_mem[r_rp];

  // a pop frees the slot a same-cycle push needs
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_wdata;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/fetch.sv
// fetch: RV32I fetch stage; owns the PC, talks req/gnt/rvalid to imem, queues to decode.
// Ports: o_imem_req/addr, i_imem_gnt/rvalid/rdata, i_redirect(_pc), o_id_valid/instr/pc/pc_plus4, i_id_ready.
module fetch #(
  parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC,
  parameter int          XLEN     = rv_pkg::XLEN,
  parameter int          DEPTH    = rv_pkg::DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_instr,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_pc_plus4
);

  import rv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_out;
  logic [CW-1:0]   r_kill;

  logic            w_hs;
  logic [CW:0]     w_used;
  logic [CW-1:0]   w_out_nxt;
  logic            w_kill_nz;
  logic            w_keep;

  logic            w_pf_pop;
  logic [XLEN-1:0] w_pf_pc;
  logic [CW-1:0]   w_pf_count;
  logic            w_pf_full;
  logic            w_pf_empty;

  if_id_t          w_q_wdata;
  if_id_t          w_q_head;
  logic            w_q_push;
  logic            w_q_pop;
  logic [CW-1:0]   w_q_count;
  logic            w_q_full;
  logic            w_q_empty;

  // credit counts every slot a response could still land in
  assign w_used     = {1'b0, r_out} + {1'b0, w_q_count};
  assign o_imem_req = (w_used < (CW+1)'(DEPTH)) & ~i_redirect;
  assign o_imem_addr = r_pc;

  assign w_hs      = o_imem_req & i_imem_gnt;
  assign w_out_nxt = r_out + CW'(w_hs) - CW'(i_imem_rvalid);
  assign w_kill_nz = (r_kill != '0);

  // killed responses were flushed from the pc fifo already
  assign w_pf_pop = i_imem_rvalid & ~w_kill_nz;
  assign w_keep   = i_imem_rvalid & ~w_kill_nz & ~i_redirect;

  assign w_q_wdata = '{pc: w_pf_pc, instr: i_imem_rdata};
  assign w_q_push  = w_keep;
  assign w_q_pop   = o_id_valid & i_id_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc   <= RESET_PC;
      r_out  <= '0;
      r_kill <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (i_redirect) begin
        r_pc   <= i_redirect_pc & IALIGN_MASK;
        r_kill <= w_out_nxt;
      end else begin
        if (w_hs) r_pc <= r_pc + XLEN'(4);
        if (i_imem_rvalid && w_kill_nz) r_kill <= r_kill - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .W     (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_hs),
    .i_wdata (r_pc),
    .i_pop   (w_pf_pop),
    .o_rdata (w_pf_pc),
    .o_count (w_pf_count),
    .o_full  (w_pf_full),
    .o_empty (w_pf_empty)
  );

  fetch_fifo #(
    .W     ($bits(if_id_t)),
    .DEPTH (DEPTH)
  ) u_iq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_q_push),
    .i_wdata (w_q_wdata),
    .i_pop   (w_q_pop),
    .o_rdata (w_q_head),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign o_id_valid    = ~w_q_empty;
  assign o_id_instr    = w_q_empty ? INSTR_NOP : w_q_head.instr;
  assign o_id_pc       = w_q_empty ? RESET_PC : w_q_head.pc;
  assign o_id_pc_plus4 = o_id_pc + XLEN'(4);

  always @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(i_imem_rvalid && r_out == '0));
      assert (w_pf_count == r_out - r_kill);
      assert (!(w_pf_pop && w_pf_empty));
      assert (!(w_hs && w_pf_full));
      assert (!(w_q_push && w_q_full && !w_q_pop));
    end
  end

endmodule
